dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 256x16 data memory between the pipeline MEM stage (core port) and a debug/loader port (dbg port).
- Core has fixed priority. A starvation counter guarantees the dbg port a grant after MAX_WAIT lost cycles.
- Returns read data one cycle after grant, tagged to the owning requester.
- Drives a stall to the pipeline whenever a core request is not granted.

Parameters:
- AW, 8, address width (data memory depth 2^AW).
- DW, 16, data width.
- MAX_WAIT, 4, consecutive lost cycles after which a pending dbg request wins (0 = dbg always wins).
- WCW, 3, width of the wait counter; must hold MAX_WAIT.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- core_req  in  1  core access request; held with addr/we/wdata until core_gnt.
- core_we  in  1  1 = write (sw), 0 = read (lw).
- core_addr  in  AW  word address.
- core_wdata  in  DW  store data.
- core_gnt  out  1  combinational grant, same cycle as access issue.
- core_rvalid  out  1  read data valid (cycle after read grant).
- core_rdata  out  DW  read data; 0 when core_rvalid=0.
- core_stall  out  1  core_req & ~core_gnt.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  same rules as core.
- dbg_gnt, dbg_rvalid  out  1  as core.
- dbg_rdata  out  DW  as core.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; registered memory, valid one cycle after mem_en & ~mem_we.

Behaviour:
- Arbitration (combinational from request inputs and the wait_cnt register):
  - dbg wins if dbg_req & (~core_req | wait_cnt >= MAX_WAIT); otherwise core wins if core_req.
  - At most one gnt per cycle. mem_en = core_gnt | dbg_gnt.
  - mem_we/addr/wdata are muxed from the winner. With no grant, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- wait_cnt:
  - Clears on reset and on dbg_gnt.
  - Increments (saturating at MAX_WAIT) in each cycle with dbg_req & ~dbg_gnt.
  - Holds when dbg_req = 0.
- Read return:
  - Registered rd_valid and rd_owner (0 = core, 1 = dbg), set on any read grant and cleared otherwise.
  - Next cycle: owner's rvalid = 1 and owner's rdata = mem_rdata. The non-owner's rvalid = 0 and rdata = 0.
  - Writes never produce rvalid.
- Latency: grant 0 cycles; read data 1 cycle after grant; back-to-back reads from alternating owners are allowed every cycle.
- Reset values: wait_cnt = 0, rd_valid = 0, rd_owner = 0. Hence both rvalid = 0, both rdata = 0, all gnt = 0 while reset is high.
- Reset mid-operation: a read granted in the cycle before reset returns no rvalid. Requests present during reset are not granted.
- Simultaneous events:
  - Both requesting with wait_cnt < MAX_WAIT: core granted.
  - Both requesting with wait_cnt == MAX_WAIT: dbg granted, core_stall = 1, wait_cnt -> 0.
- MAX_WAIT = 0: dbg has strict priority, and core_stall is asserted whenever both request.
- No reordering or buffering: each requester has at most one outstanding read.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, adds output ports core_grant_cnt, dbg_grant_cnt and stall_cnt, each 16 bits. They are saturating counters of core grants, dbg grants, and cycles with core_stall = 1. All clear on reset.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - Owner encoding constants OWN_CORE = 0 and OWN_DBG = 1.
  - Default AW/DW.
  - Opcode constants OP_LOAD = 7'b0000011 and OP_STORE = 7'b0100011, used by the MEM-stage glue.
- One natural sub-module, dmem_arb_wait_ctr: a saturating wait counter with clear/increment/hold.

Test Plan:
- Reset, then core read addr 0x00 with mem holding 0x000F -> core_gnt same cycle; next cycle core_rvalid = 1, core_rdata = 0x000F; dbg_rvalid = 0.
- dbg write addr 0x10 data 0xBEEF with core idle -> dbg_gnt, mem_we = 1, mem_addr = 0x10, mem_wdata = 0xBEEF; no rvalid on either port.
- core_req and dbg_req held high continuously, MAX_WAIT = 4 -> core granted cycles 0–3, dbg granted cycle 4 with core_stall = 1, core granted again from cycle 5; pattern repeats every 5 cycles.
- Alternating core read 0x01 and dbg read 0x02 on consecutive cycles -> rvalid and data go to the correct owner each cycle, with no crosstalk (non-owner rdata = 0).
- Core read granted, reset asserted the next cycle -> no core_rvalid, wait_cnt = 0, all gnt = 0 while reset is high.
- With DMEM_ARB_STATS_EN, 10-cycle contention at MAX_WAIT = 4 -> core_grant_cnt = 8, dbg_grant_cnt = 2, stall_cnt = 2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter and MEM-stage glue.
// Owner tags, default widths and load/store opcodes.
package dmem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of cycles the dbg port has lost arbitration.
// sat_o flags that the dbg port must win its next request.
module dmem_arb_wait_ctr #(
  parameter int WCW      = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam logic [WCW-1:0] MAXV = WCW'(MAX_WAIT);

  logic [WCW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q < MAXV))
      cnt_d = cnt_q + WCW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q >= MAXV);

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single-port data memory.
// Define DMEM_ARB_STATS_EN to add grant/stall statistics counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = 4,
  parameter int WCW      = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   core_grant_cnt,
  output logic [15:0]   dbg_grant_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  logic   wait_sat;
  logic   rd_valid_q, rd_valid_d;
  owner_e rd_owner_q, rd_owner_d;

  // No grants while reset is high, even with requests pending.
  assign dbg_gnt  = ~reset & dbg_req & (~core_req | wait_sat);
  assign core_gnt = ~reset & core_req & ~dbg_gnt;

  assign core_stall = core_req & ~core_gnt;
  assign mem_en     = core_gnt | dbg_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      core_gnt: begin
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      dbg_gnt: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  dmem_arb_wait_ctr #(
    .WCW      (WCW),
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clock (clock),
    .reset (reset),
    .clr_i (dbg_gnt),
    .inc_i (dbg_req & ~dbg_gnt),
    .sat_o (wait_sat)
  );

  always_comb begin
    rd_valid_d = mem_en & ~mem_we;
    rd_owner_d = dbg_gnt ? OWN_DBG : OWN_CORE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // A read in flight when reset rises is dropped.
  assign core_rvalid = ~reset & rd_valid_q & (rd_owner_q == OWN_CORE);
  assign dbg_rvalid  = ~reset & rd_valid_q & (rd_owner_q == OWN_DBG);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cg_cnt_q, dg_cnt_q, st_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cg_cnt_q <= '0;
      dg_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      if (core_gnt && (cg_cnt_q != '1))
        cg_cnt_q <= cg_cnt_q + 16'd1;
      if (dbg_gnt && (dg_cnt_q != '1))
        dg_cnt_q <= dg_cnt_q + 16'd1;
      if (core_stall && (st_cnt_q != '1))
        st_cnt_q <= st_cnt_q + 16'd1;
    end
  end

  assign core_grant_cnt = cg_cnt_q;
  assign dbg_grant_cnt  = dg_cnt_q;
  assign stall_cnt      = st_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner
// sequences and random traffic against a behavioural model.
module tb_dmem_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int MW  = 4;
  localparam int WCW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          core_req = 0, core_we = 0;
  logic [AW-1:0] core_addr = 0;
  logic [DW-1:0] core_wdata = 0;
  logic          dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] dbg_addr = 0;
  logic [DW-1:0] dbg_wdata = 0;
  logic          core_gnt, core_rvalid, core_stall;
  logic [DW-1:0] core_rdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   core_grant_cnt, dbg_grant_cnt, stall_cnt;
`endif

  dmem_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MW), .WCW(WCW)
  ) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .core_grant_cnt(core_grant_cnt),
    .dbg_grant_cnt(dbg_grant_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Registered single-port memory seen by the DUT.
  logic [DW-1:0] mem [256];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       rst, creq, cwe;
    logic [7:0] caddr;
    logic [15:0] cwd;
    logic       dreq, dwe;
    logic [7:0] daddr;
    logic [15:0] dwd;
  } in_t;

  typedef struct {
    in_t         i;
    logic        cg, dg, st, crv, drv, men, mwe;
    logic [15:0] crd, drd, mwd;
    logic [7:0]  maddr;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model state
  int          wcnt = 0;
  bit          pv = 0;
  bit          po = 0;
  logic [15:0] pd = '0;
  logic [15:0] rmem [256];
  int          s_cg = 0, s_dg = 0, s_st = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic in_t mk(input logic rst, creq, cwe,
      input logic [7:0] ca, input logic [15:0] cd,
      input logic dreq, dwe, input logic [7:0] da,
      input logic [15:0] dd);
    in_t r;
    r.rst = rst; r.creq = creq; r.cwe = cwe;
    r.caddr = ca; r.cwd = cd;
    r.dreq = dreq; r.dwe = dwe;
    r.daddr = da; r.dwd = dd;
    return r;
  endfunction

  function automatic vec_t mv(input in_t i,
      input logic cg, dg, st, crv, input logic [15:0] crd,
      input logic drv, input logic [15:0] drd,
      input logic men, mwe, input logic [7:0] ma,
      input logic [15:0] mwd);
    vec_t v;
    v.i = i; v.cg = cg; v.dg = dg; v.st = st;
    v.crv = crv; v.crd = crd; v.drv = drv; v.drd = drd;
    v.men = men; v.mwe = mwe; v.maddr = ma; v.mwd = mwd;
    return v;
  endfunction

  // One clock cycle: drive, compare against the model, advance it.
  task automatic step(input in_t v);
    logic        e_cg, e_dg, e_st, e_crv, e_drv, e_mwe;
    logic [15:0] e_crd, e_drd, e_mwd;
    logic [7:0]  e_ma;
    string       p;
    @(negedge clock);
    reset = v.rst;
    core_req = v.creq; core_we = v.cwe;
    core_addr = v.caddr; core_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe;
    dbg_addr = v.daddr; dbg_wdata = v.dwd;
    #1;
    e_cg = 0; e_dg = 0; e_crv = 0; e_drv = 0;
    e_crd = 0; e_drd = 0; e_mwe = 0; e_ma = 0; e_mwd = 0;
    if (!v.rst) begin
      e_dg = v.dreq && (!v.creq || wcnt >= MW);
      e_cg = v.creq && !e_dg;
      if (pv && !po) begin e_crv = 1; e_crd = pd; end
      if (pv && po)  begin e_drv = 1; e_drd = pd; end
    end
    e_st = v.creq && !e_cg;
    if (e_cg) begin
      e_mwe = v.cwe; e_ma = v.caddr; e_mwd = v.cwd;
    end else if (e_dg) begin
      e_mwe = v.dwe; e_ma = v.daddr; e_mwd = v.dwd;
    end
    p = $sformatf("cyc%0d", cyc);
    chk({p, " core_gnt"}, 32'(core_gnt), 32'(e_cg));
    chk({p, " dbg_gnt"}, 32'(dbg_gnt), 32'(e_dg));
    chk({p, " core_stall"}, 32'(core_stall), 32'(e_st));
    chk({p, " core_rvalid"}, 32'(core_rvalid), 32'(e_crv));
    chk({p, " core_rdata"}, 32'(core_rdata), 32'(e_crd));
    chk({p, " dbg_rvalid"}, 32'(dbg_rvalid), 32'(e_drv));
    chk({p, " dbg_rdata"}, 32'(dbg_rdata), 32'(e_drd));
    chk({p, " mem_en"}, 32'(mem_en), 32'(e_cg | e_dg));
    chk({p, " mem_we"}, 32'(mem_we), 32'(e_mwe));
    chk({p, " mem_addr"}, 32'(mem_addr), 32'(e_ma));
    chk({p, " mem_wdata"}, 32'(mem_wdata), 32'(e_mwd));
`ifdef DMEM_ARB_STATS_EN
    chk({p, " core_grant_cnt"}, 32'(core_grant_cnt), 32'(s_cg));
    chk({p, " dbg_grant_cnt"}, 32'(dbg_grant_cnt), 32'(s_dg));
    chk({p, " stall_cnt"}, 32'(stall_cnt), 32'(s_st));
`endif
    if (v.rst) begin
      wcnt = 0; pv = 0; po = 0;
      s_cg = 0; s_dg = 0; s_st = 0;
    end else begin
      if (e_dg) wcnt = 0;
      else if (v.dreq && wcnt < MW) wcnt++;
      pv = (e_cg || e_dg) && !e_mwe;
      po = e_dg;
      if (pv) pd = rmem[e_ma];
      if ((e_cg || e_dg) && e_mwe) rmem[e_ma] = e_mwd;
      if (e_cg && s_cg < 65535) s_cg++;
      if (e_dg && s_dg < 65535) s_dg++;
      if (e_st && s_st < 65535) s_st++;
    end
    cyc++;
  endtask

  task automatic chk_vec(input vec_t t, input int k);
    string p;
    p = $sformatf("tbl%0d", k);
    chk({p, " core_gnt"}, 32'(core_gnt), 32'(t.cg));
    chk({p, " dbg_gnt"}, 32'(dbg_gnt), 32'(t.dg));
    chk({p, " core_stall"}, 32'(core_stall), 32'(t.st));
    chk({p, " core_rvalid"}, 32'(core_rvalid), 32'(t.crv));
    chk({p, " core_rdata"}, 32'(core_rdata), 32'(t.crd));
    chk({p, " dbg_rvalid"}, 32'(dbg_rvalid), 32'(t.drv));
    chk({p, " dbg_rdata"}, 32'(dbg_rdata), 32'(t.drd));
    chk({p, " mem_en"}, 32'(mem_en), 32'(t.men));
    chk({p, " mem_we"}, 32'(mem_we), 32'(t.mwe));
    chk({p, " mem_addr"}, 32'(mem_addr), 32'(t.maddr));
    chk({p, " mem_wdata"}, 32'(mem_wdata), 32'(t.mwd));
  endtask

  initial begin
    vec_t tbl [10];
    in_t  idle, both;
    logic [15:0] w;

    for (int a = 0; a < 256; a++) begin
      w = 16'($urandom);
      if (a == 0) w = 16'h000F;
      if (a == 1) w = 16'h1111;
      if (a == 2) w = 16'h2222;
      mem[a] = w;
      rmem[a] = w;
    end

    idle = mk(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
    both = mk(0, 1, 0, 8'h03, 16'h0, 1, 0, 8'h04, 16'h0);

    tbl[0] = mv(mk(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0),
                0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0, 8'h00, 16'h0);
    tbl[1] = mv(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0),
                1, 0, 0, 0, 16'h0, 0, 16'h0, 1, 0, 8'h00, 16'h0);
    tbl[2] = mv(idle,
                0, 0, 0, 1, 16'h000F, 0, 16'h0, 0, 0, 8'h00, 16'h0);
    tbl[3] = mv(mk(0, 0, 0, 8'h00, 0, 1, 1, 8'h10, 16'hBEEF),
                0, 1, 0, 0, 16'h0, 0, 16'h0, 1, 1, 8'h10, 16'hBEEF);
    tbl[4] = mv(idle,
                0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 8'h00, 16'h0);
    tbl[5] = mv(mk(0, 1, 0, 8'h01, 0, 0, 0, 8'h00, 0),
                1, 0, 0, 0, 16'h0, 0, 16'h0, 1, 0, 8'h01, 16'h0);
    tbl[6] = mv(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h02, 0),
                0, 1, 0, 1, 16'h1111, 0, 16'h0, 1, 0, 8'h02, 16'h0);
    tbl[7] = mv(mk(0, 1, 0, 8'h01, 0, 0, 0, 8'h00, 0),
                1, 0, 0, 0, 16'h0, 1, 16'h2222, 1, 0, 8'h01, 16'h0);
    tbl[8] = mv(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h10, 0),
                0, 1, 0, 1, 16'h1111, 0, 16'h0, 1, 0, 8'h10, 16'h0);
    tbl[9] = mv(idle,
                0, 0, 0, 0, 16'h0, 1, 16'hBEEF, 0, 0, 8'h00, 16'h0);

    for (int k = 0; k < 10; k++) begin
      step(tbl[k].i);
      chk_vec(tbl[k], k);
    end

    // Sustained contention: four core grants, then one dbg grant.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      step(both);
      chk($sformatf("cont%0d core_gnt", i), 32'(core_gnt),
          32'((i % 5) != 4));
      chk($sformatf("cont%0d core_stall", i), 32'(core_stall),
          32'((i % 5) == 4));
    end
    step(idle);
`ifdef DMEM_ARB_STATS_EN
    chk("stats core_grant_cnt", 32'(core_grant_cnt), 32'd8);
    chk("stats dbg_grant_cnt", 32'(dbg_grant_cnt), 32'd2);
    chk("stats stall_cnt", 32'(stall_cnt), 32'd2);
`endif

    // Reset right after a core read; wait count must also clear.
    for (int i = 0; i < 3; i++) step(both);
    step(mk(0, 1, 0, 8'h05, 0, 0, 0, 0, 0));
    chk("rstmid core_gnt_pre", 32'(core_gnt), 32'd1);
    step(mk(1, 1, 0, 8'h05, 0, 1, 0, 8'h06, 0));
    chk("rstmid core_rvalid", 32'(core_rvalid), 32'd0);
    chk("rstmid core_gnt", 32'(core_gnt), 32'd0);
    chk("rstmid dbg_gnt", 32'(dbg_gnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(both);
      chk($sformatf("postrst%0d dbg_gnt", i), 32'(dbg_gnt),
          32'(i == 4));
    end

    for (int n = 0; n < 3000; n++) begin
      in_t r;
      r = mk($urandom_range(0, 40) == 0,
             1'($urandom), 1'($urandom),
             8'($urandom_range(0, 15)), 16'($urandom),
             1'($urandom), 1'($urandom),
             8'($urandom_range(0, 15)), 16'($urandom));
      step(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
